// File: rtl/xadc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xadc_pkg : shared XADC DRP constants and sequencer state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package xadc_pkg;

  localparam int DRP_DATA_W = 16;

  localparam logic [6:0] XADC_TEMP   = 7'h00;
  localparam logic [6:0] XADC_VAUX3  = 7'h13;
  localparam logic [6:0] XADC_VAUX11 = 7'h1b;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STORE = 2'd3
  } xadc_state_e;

endpackage
`default_nettype wire

// File: rtl/xadc_avg_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xadc_avg_acc : per-channel accumulate-and-shift averager with valid strobe
// Rev 1.0
// ---------------------------------------------------------------------------
module xadc_avg_acc
  import xadc_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              last,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] avg,
  output logic              valid
);

  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              valid_q, valid_d;

  // 2^AVG_LOG2 samples of DATA_W bits always fit in ACC_W, so no overflow.
  assign sum = acc_q + ACC_W'(sample);

  always_comb begin
    acc_d   = acc_q;
    avg_d   = avg_q;
    valid_d = 1'b0;
    if (en) begin
      if (last) begin
        acc_d   = '0;
        avg_d   = sum[ACC_W-1 -: DATA_W];
        valid_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      avg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
    end
  end

  assign avg   = avg_q;
  assign valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/xadc_channel_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xadc_channel_sequencer : round-robin XADC DRP reader with optional averaging
// Rev 1.0
// ---------------------------------------------------------------------------
module xadc_channel_sequencer
  import xadc_pkg::*;
#(
  parameter int                  NUM_CH   = 2,
  parameter int                  DATA_W   = 12,
  parameter logic [NUM_CH*7-1:0] CH_ADDRS = {XADC_VAUX11, XADC_VAUX3},
  parameter int                  AVG_LOG2 = 0,
  parameter int                  TIMEOUT  = 63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     eoc_in,
  input  logic                     drp_drdy,
  input  logic [DRP_DATA_W-1:0]    drp_do,
  output logic                     drp_den,
  output logic                     drp_dwe,
  output logic [6:0]               drp_daddr,
  output logic [NUM_CH*DATA_W-1:0] samples,
  output logic [NUM_CH-1:0]        sample_valid,
  output logic                     overrun,
  output logic                     timeout
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RND_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_CH - 1);
  localparam logic [RND_W-1:0] ROUND_LAST = RND_W'((1 << AVG_LOG2) - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);

  xadc_state_e       state_q, state_d;
  logic              pending_q, pending_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [RND_W-1:0]  round_q, round_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [6:0]        daddr_q, daddr_d;
  logic              den_q, den_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic              store_en;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    round_d   = round_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    den_d     = 1'b0;
    overrun_d = 1'b0;
    timeout_d = 1'b0;
    store_en  = 1'b0;

    // A second conversion arriving while one is already queued is lost.
    if (eoc_in && (state_q != ST_IDLE)) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (eoc_in || pending_q) begin
          state_d   = ST_REQ;
          den_d     = 1'b1;
          pending_d = pending_q && eoc_in;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (drp_drdy) begin
          data_d  = drp_do[DRP_DATA_W-1 -: DATA_W];
          state_d = ST_STORE;
        end else if (cnt_q >= TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STORE: begin
        store_en = 1'b1;
        state_d  = ST_IDLE;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          round_d = (round_q == ROUND_LAST) ? '0 : round_q + 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    daddr_d = CH_ADDRS[7*idx_d +: 7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      idx_q     <= '0;
      round_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      daddr_q   <= CH_ADDRS[6:0];
      den_q     <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      round_q   <= round_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      daddr_q   <= daddr_d;
      den_q     <= den_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    xadc_avg_acc #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
      .clk    (clk),
      .rst    (rst),
      .en     (store_en && (idx_q == IDX_W'(k))),
      .last   (round_q == ROUND_LAST),
      .sample (data_q),
      .avg    (samples[DATA_W*k +: DATA_W]),
      .valid  (sample_valid[k])
    );
  end

  if (DATA_W < DRP_DATA_W) begin : g_unused_lsbs
    logic unused_lsbs;
    assign unused_lsbs = ^drp_do[DRP_DATA_W-DATA_W-1:0];
  end

  assign drp_den   = den_q;
  assign drp_dwe   = 1'b0;
  assign drp_daddr = daddr_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire
